// File: rtl/regfile_2w2r_sb.sv
// Parametrised register file: two registered read ports, two write ports and a
// per-register busy scoreboard that tells decode which operands are still in flight.
module regfile_2w2r_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            rd_en,
  input  logic [AW-1:0]   src_a,
  input  logic [AW-1:0]   src_b,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  input  logic            flush
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] hit0;
  logic [NREGS-1:0] hit1;
  logic [XLEN-1:0] op_a_next;
  logic [XLEN-1:0] op_b_next;

  // Per-register write hits and scoreboard update; a hard-wired zero register
  // never sees a write and is never busy.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (ZERO_REG && gi == 0) begin : g_zero
      assign hit0[gi]      = 1'b0;
      assign hit1[gi]      = 1'b0;
      assign busy_next[gi] = 1'b0;
    end else begin : g_norm
      assign hit0[gi] = we0 && (waddr0 == AW'(gi));
      assign hit1[gi] = we1 && (waddr1 == AW'(gi));
      // A same-edge issue wins over a write: the issued instruction is the new producer.
      assign busy_next[gi] = flush                                ? 1'b0 :
                             (issue_en && issue_addr == AW'(gi))  ? 1'b1 :
                             (hit0[gi] || hit1[gi])               ? 1'b0 :
                                                                    busy_reg[gi];
    end
  end

  always_comb begin
    op_a_next = regs[src_a];
    op_b_next = regs[src_b];
    if (BYPASS) begin
      if (hit1[src_a])      op_a_next = wdata1;
      else if (hit0[src_a]) op_a_next = wdata0;
      if (hit1[src_b])      op_b_next = wdata1;
      else if (hit0[src_b]) op_b_next = wdata0;
    end
    if (ZERO_REG && src_a == '0) op_a_next = '0;
    if (ZERO_REG && src_b == '0) op_b_next = '0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy_reg <= '0;
      op_a     <= '0;
      op_b     <= '0;
      busy_a   <= 1'b0;
      busy_b   <= 1'b0;
    end else begin
      // Port 1 (load) takes priority when both ports target one register.
      for (int i = 0; i < NREGS; i++) begin
        if (hit1[i])      regs[i] <= wdata1;
        else if (hit0[i]) regs[i] <= wdata0;
      end
      busy_reg <= busy_next;
      if (rd_en) begin
        op_a   <= op_a_next;
        op_b   <= op_b_next;
        busy_a <= busy_next[src_a];
        busy_b <= busy_next[src_b];
      end
    end
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Table-driven bench for regfile_2w2r_sb; a second instance with BYPASS=0 shares
// all inputs so the non-forwarding read path is checked on the same vectors.
module tb_regfile_2w2r_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct {
    logic            rd_en;
    logic [AW-1:0]   src_a, src_b;
    logic            we0;
    logic [AW-1:0]   waddr0;
    logic [XLEN-1:0] wdata0;
    logic            we1;
    logic [AW-1:0]   waddr1;
    logic [XLEN-1:0] wdata1;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic            flush;
    logic [XLEN-1:0] exp_a, exp_b;
    logic            exp_ba, exp_bb;
    logic [XLEN-1:0] exp_a_nb;
    int              id;
  } vec_t;

  logic            clk = 1'b0;
  logic            clrn;
  logic            rd_en;
  logic [AW-1:0]   src_a, src_b;
  logic [XLEN-1:0] op_a, op_b, op_a_nb, op_b_nb;
  logic            busy_a, busy_b, busy_a_nb, busy_b_nb;
  logic            we0, we1;
  logic [AW-1:0]   waddr0, waddr1;
  logic [XLEN-1:0] wdata0, wdata1;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic            flush;

  int tests  = 0;
  int failed = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  regfile_2w2r_sb #(.XLEN(XLEN), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .clrn(clrn), .rd_en(rd_en), .src_a(src_a), .src_b(src_b),
    .op_a(op_a), .op_b(op_b), .busy_a(busy_a), .busy_b(busy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
  );

  regfile_2w2r_sb #(.XLEN(XLEN), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .clrn(clrn), .rd_en(rd_en), .src_a(src_a), .src_b(src_b),
    .op_a(op_a_nb), .op_b(op_b_nb), .busy_a(busy_a_nb), .busy_b(busy_b_nb),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
  );

  function automatic vec_t mkv(
    input logic r, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
    input logic w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
    input logic w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
    input logic is, input logic [AW-1:0] ia, input logic fl,
    input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb,
    input logic eba, input logic ebb, input logic [XLEN-1:0] eanb);
    vec_t v;
    v.rd_en = r; v.src_a = sa; v.src_b = sb;
    v.we0 = w0; v.waddr0 = a0; v.wdata0 = d0;
    v.we1 = w1; v.waddr1 = a1; v.wdata1 = d1;
    v.issue_en = is; v.issue_addr = ia; v.flush = fl;
    v.exp_a = ea; v.exp_b = eb; v.exp_ba = eba; v.exp_bb = ebb; v.exp_a_nb = eanb;
    v.id = 0;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s vec%0d: got %h, expected %h", name, id, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rd_en = v.rd_en; src_a = v.src_a; src_b = v.src_b;
    we0 = v.we0; waddr0 = v.waddr0; wdata0 = v.wdata0;
    we1 = v.we1; waddr1 = v.waddr1; wdata1 = v.wdata1;
    issue_en = v.issue_en; issue_addr = v.issue_addr; flush = v.flush;
  endtask

  // Drive one vector, queue its expectation, then compare after the capturing edge.
  task automatic apply(input vec_t v);
    vec_t e;
    drive(v);
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard vec%0d: got empty queue, expected 1 entry", v.id);
    end else begin
      e = sb_q.pop_front();
      chk("op_a",    e.id, op_a,    e.exp_a);
      chk("op_b",    e.id, op_b,    e.exp_b);
      chk("busy_a",  e.id, XLEN'(busy_a), XLEN'(e.exp_ba));
      chk("busy_b",  e.id, XLEN'(busy_b), XLEN'(e.exp_bb));
      chk("op_a_nb", e.id, op_a_nb, e.exp_a_nb);
      $display("[TB] vec%0d rd=%0b a=%0d b=%0d -> op_a=%h op_b=%h busy=%0b%0b op_a_nb=%h",
               e.id, e.rd_en, e.src_a, e.src_b, op_a, op_b, busy_a, busy_b, op_a_nb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mkv(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
    clrn = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_a",   -1, op_a, '0);
    chk("rst_op_b",   -1, op_b, '0);
    chk("rst_busy_a", -1, XLEN'(busy_a), '0);
    clrn = 1'b1;

    // ZERO_REG, bypass, collision, scoreboard, flush
    vecs.push_back(mkv(1,0,0,   1,0,32'h1234,      0,0,0,             1,0,0,  0,0,0,0, 0));
    vecs.push_back(mkv(1,0,0,   0,0,0,             0,0,0,             0,0,0,  0,0,0,0, 0));
    vecs.push_back(mkv(1,3,0,   1,3,32'hA5A5A5A5,  0,0,0,             0,0,0,  32'hA5A5A5A5,0,0,0, 0));
    vecs.push_back(mkv(1,3,3,   0,0,0,             0,0,0,             0,0,0,  32'hA5A5A5A5,32'hA5A5A5A5,0,0, 32'hA5A5A5A5));
    vecs.push_back(mkv(1,7,7,   1,7,32'h11,        1,7,32'h22,        0,0,0,  32'h22,32'h22,0,0, 0));
    vecs.push_back(mkv(1,7,7,   0,0,0,             0,0,0,             0,0,0,  32'h22,32'h22,0,0, 32'h22));
    vecs.push_back(mkv(1,9,3,   0,0,0,             0,0,0,             1,9,0,  0,32'hA5A5A5A5,1,0, 0));
    vecs.push_back(mkv(1,9,9,   0,0,0,             1,9,32'h99,        0,0,0,  32'h99,32'h99,0,0, 0));
    vecs.push_back(mkv(1,9,9,   1,9,32'h77,        0,0,0,             1,9,0,  32'h77,32'h77,1,1, 32'h99));
    vecs.push_back(mkv(1,9,9,   0,0,0,             0,0,0,             0,0,0,  32'h77,32'h77,1,1, 32'h77));
    vecs.push_back(mkv(1,12,9,  0,0,0,             0,0,0,             1,12,0, 0,32'h77,1,1, 0));
    vecs.push_back(mkv(1,12,5,  0,0,0,             0,0,0,             1,5,1,  0,0,0,0, 0));
    vecs.push_back(mkv(1,9,12,  0,0,0,             0,0,0,             0,0,0,  32'h77,0,0,0, 32'h77));
    vecs.push_back(mkv(1,21,20, 1,20,32'hCAFEF00D, 1,21,32'h0BADF00D, 0,0,0,  32'h0BADF00D,32'hCAFEF00D,0,0, 0));
    // Stall: r4 changes while rd_en=0, outputs hold, then pick up the newest value
    vecs.push_back(mkv(1,4,9,   1,4,32'h44,        0,0,0,             0,0,0,  32'h44,32'h77,0,0, 0));
    vecs.push_back(mkv(0,4,4,   1,4,32'h100,       0,0,0,             0,0,0,  32'h44,32'h77,0,0, 0));
    vecs.push_back(mkv(0,4,4,   1,4,32'h200,       0,0,0,             0,0,0,  32'h44,32'h77,0,0, 0));
    vecs.push_back(mkv(0,4,4,   1,4,32'h300,       0,0,0,             1,4,0,  32'h44,32'h77,0,0, 0));
    vecs.push_back(mkv(1,4,4,   0,0,0,             0,0,0,             0,0,0,  32'h300,32'h300,1,1, 32'h300));
    // Set up r5 before the reset sequence
    vecs.push_back(mkv(1,5,5,   1,5,32'hDEADBEEF,  0,0,0,             1,5,0,  32'hDEADBEEF,32'hDEADBEEF,1,1, 0));

    foreach (vecs[i]) begin
      vecs[i].id = i;
      apply(vecs[i]);
    end

    // Asynchronous reset mid-cycle, with a write held across an edge during reset
    #2;
    clrn = 1'b0;
    #1;
    chk("async_op_a",   100, op_a, '0);
    chk("async_busy_a", 100, XLEN'(busy_a), '0);
    drive(mkv(1,5,5, 1,5,32'h5555, 0,0,0, 1,5,0, 0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("inrst_op_a", 101, op_a, '0);
    clrn = 1'b1;
    begin
      vec_t v;
      v = mkv(1,5,4, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0);
      v.id = 102;
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
